bcd_counter_n: RTL and testbench

//  Synchronous multi-decade BCD counter: DIGITS cascaded 4-bit decades in one register.

---
 rtl/bcd_counter_n.sv | 78 +++++++
 tb/tb_bcd_counter_n.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_n.sv
// Multi-decade BCD up/down counter with parallel load, synchronous clear and
// wrap or saturate behaviour at the terminal count; co cascades into a further stage.
module bcd_counter_n #(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   d,
  input  logic                  en,
  input  logic                  up,
  output logic [4*DIGITS-1:0]   q,
  output logic                  tc,
  output logic                  co
);

  logic [4*DIGITS-1:0] q_next;
  logic [4*DIGITS-1:0] load_val;
  logic [4*DIGITS-1:0] step_val;
  logic [DIGITS:0]     run_nine;
  logic [DIGITS:0]     run_zero;
  logic                step_en;

  // run_nine[i] / run_zero[i]: every digit below i is 9 / 0, i.e. digit i receives the carry/borrow.
  always_comb begin
    run_nine    = '0;
    run_zero    = '0;
    run_nine[0] = 1'b1;
    run_zero[0] = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      run_nine[i+1] = run_nine[i] & (q[4*i +: 4] == 4'd9);
      run_zero[i+1] = run_zero[i] & (q[4*i +: 4] == 4'd0);
    end
  end

  assign tc = up ? run_nine[DIGITS] : run_zero[DIGITS];
  assign co = en & tc & ~clr & ~load;

  // In saturate mode an enabled step at the terminal is suppressed; co still reports it.
  assign step_en = en & ~(tc & (WRAP == 1'b0));

  always_comb begin
    load_val = '0;
    step_val = q;
    for (int i = 0; i < DIGITS; i++) begin
      load_val[4*i +: 4] = (d[4*i +: 4] > 4'd9) ? 4'd9 : d[4*i +: 4];
      if (up && run_nine[i]) begin
        // Codes 10..15 fold to 0 so a corrupted digit recovers on its next step.
        step_val[4*i +: 4] = (q[4*i +: 4] >= 4'd9) ? 4'd0 : q[4*i +: 4] + 4'd1;
      end else if (!up && run_zero[i]) begin
        step_val[4*i +: 4] = ((q[4*i +: 4] == 4'd0) || (q[4*i +: 4] > 4'd9)) ?
                             4'd9 : q[4*i +: 4] - 4'd1;
      end
    end
  end

  always_comb begin
    q_next = q;
    if (clr) begin
      q_next = '0;
    end else if (load) begin
      q_next = load_val;
    end else if (step_en) begin
      q_next = step_val;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: tb/tb_bcd_counter_n.sv
// Bench for bcd_counter_n: a 2-digit wrap instance, a 2-digit saturate instance and
// two cascaded 1-digit instances, all checked against integer-valued decimal models.
module tb_bcd_counter_n;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  logic       s_clr, s_load, s_en, s_up;
  logic [7:0] s_d;

  logic [7:0] qa, qs;
  logic       tca, coa, tcs, cos;
  logic [3:0] qc0, qc1;
  logic       tc0, co0, tc1, co1;

  bcd_counter_n #(.DIGITS(2), .WRAP(1'b1)) dut_a (
    .clk(clk), .nrst(nrst), .clr(s_clr), .load(s_load), .d(s_d), .en(s_en), .up(s_up),
    .q(qa), .tc(tca), .co(coa));

  bcd_counter_n #(.DIGITS(2), .WRAP(1'b0)) dut_s (
    .clk(clk), .nrst(nrst), .clr(s_clr), .load(s_load), .d(s_d), .en(s_en), .up(s_up),
    .q(qs), .tc(tcs), .co(cos));

  bcd_counter_n #(.DIGITS(1), .WRAP(1'b1)) dut_c0 (
    .clk(clk), .nrst(nrst), .clr(s_clr), .load(s_load), .d(s_d[3:0]), .en(s_en), .up(s_up),
    .q(qc0), .tc(tc0), .co(co0));

  bcd_counter_n #(.DIGITS(1), .WRAP(1'b1)) dut_c1 (
    .clk(clk), .nrst(nrst), .clr(s_clr), .load(s_load), .d(s_d[7:4]), .en(co0), .up(s_up),
    .q(qc1), .tc(tc1), .co(co1));

  // ---------------- reference model ----------------
  int checks = 0;
  int errors = 0;
  int m_a = 0;
  int m_s = 0;

  function automatic int clamp_val(input logic [7:0] dv);
    int hi, lo;
    hi = (dv[7:4] > 4'd9) ? 9 : int'(dv[7:4]);
    lo = (dv[3:0] > 4'd9) ? 9 : int'(dv[3:0]);
    return hi * 10 + lo;
  endfunction

  function automatic int model_next(input int v, input logic c, input logic l,
                                    input logic [7:0] dv, input logic e, input logic u,
                                    input bit wrap);
    if (c) return 0;
    if (l) return clamp_val(dv);
    if (!e) return v;
    if (u) return (v == 99) ? (wrap ? 0 : 99) : v + 1;
    return (v == 0) ? (wrap ? 99 : 0) : v - 1;
  endfunction

  function automatic logic model_tc(input int v, input logic u);
    return u ? (v == 99) : (v == 0);
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge: applies inputs, checks combinational outputs, clocks, checks q.
  task automatic step(input logic c, input logic l, input logic [7:0] dv,
                      input logic e, input logic u);
    logic exp_co_a, exp_co_s;
    s_clr = c; s_load = l; s_d = dv; s_en = e; s_up = u;
    #1;
    exp_co_a = e & model_tc(m_a, u) & ~c & ~l;
    exp_co_s = e & model_tc(m_s, u) & ~c & ~l;
    check("tc_a", {31'd0, tca}, {31'd0, model_tc(m_a, u)});
    check("co_a", {31'd0, coa}, {31'd0, exp_co_a});
    check("tc_s", {31'd0, tcs}, {31'd0, model_tc(m_s, u)});
    check("co_s", {31'd0, cos}, {31'd0, exp_co_s});
    check("tc_casc", {31'd0, tc0 & tc1}, {31'd0, model_tc(m_a, u)});
    check("co_casc", {31'd0, co1}, {31'd0, exp_co_a});
    @(posedge clk);
    m_a = model_next(m_a, c, l, dv, e, u, 1'b1);
    m_s = model_next(m_s, c, l, dv, e, u, 1'b0);
    @(negedge clk);
    check("q_a", {24'd0, qa}, {24'd0, to_bcd(m_a)});
    check("q_s", {24'd0, qs}, {24'd0, to_bcd(m_s)});
    check("q_casc", {24'd0, qc1, qc0}, {24'd0, to_bcd(m_a)});
  endtask

  // ---------------- directed vector table (wrap instance) ----------------
  typedef struct {
    logic       clr;
    logic       load;
    logic [7:0] d;
    logic       en;
    logic       up;
    logic       exp_tc;
    logic       exp_co;
    logic [7:0] exp_q;
  } vec_t;

  vec_t vecs[12];
  int   wraps;

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 8'h98, 1'b0, 1'b1, 1'b0, 1'b0, 8'h98};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h99};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01};
    vecs[4]  = '{1'b1, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[5]  = '{1'b0, 1'b1, 8'hA7, 1'b1, 1'b1, 1'b0, 1'b0, 8'h97};
    vecs[6]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'h99};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h99};
    vecs[8]  = '{1'b0, 1'b1, 8'h12, 1'b1, 1'b1, 1'b1, 1'b0, 8'h12};
    vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h99};

    s_clr = 1'b0; s_load = 1'b0; s_d = 8'h00; s_en = 1'b0; s_up = 1'b1;
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_q_a", {24'd0, qa}, 32'h0);
    check("reset_q_s", {24'd0, qs}, 32'h0);
    check("reset_q_casc", {24'd0, qc1, qc0}, 32'h0);
    nrst = 1'b1;

    // T1: asynchronous reset mid-cycle, then first count edge
    step(1'b0, 1'b1, 8'h37, 1'b0, 1'b1);
    check("t1_loaded", {24'd0, qa}, 32'h37);
    #1 nrst = 1'b0;
    #1;
    check("t1_async_q_a", {24'd0, qa}, 32'h0);
    check("t1_async_q_casc", {24'd0, qc1, qc0}, 32'h0);
    #1 nrst = 1'b1;
    m_a = 0; m_s = 0;
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("t1_first_edge", {24'd0, qa}, 32'h01);

    // T2 / T5 and priority corners from the table
    for (int i = 0; i < 12; i++) begin
      s_clr = vecs[i].clr; s_load = vecs[i].load; s_d = vecs[i].d;
      s_en = vecs[i].en; s_up = vecs[i].up;
      #1;
      check($sformatf("vec%0d_tc", i), {31'd0, tca}, {31'd0, vecs[i].exp_tc});
      check($sformatf("vec%0d_co", i), {31'd0, coa}, {31'd0, vecs[i].exp_co});
      #1;
      step(vecs[i].clr, vecs[i].load, vecs[i].d, vecs[i].en, vecs[i].up);
      check($sformatf("vec%0d_q", i), {24'd0, qa}, {24'd0, vecs[i].exp_q});
    end

    // T3: down-count with borrow across the decade and wrap to 99
    step(1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("t3_10_to_09", {24'd0, qa}, 32'h09);
    repeat (9) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("t3_at_00", {24'd0, qa}, 32'h00);
    check("t3_co_at_00", {31'd0, coa}, 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("t3_wrap_99", {24'd0, qa}, 32'h99);
    step(1'b0, 1'b1, 8'h20, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("t3_20_to_19", {24'd0, qa}, 32'h19);

    // T4: saturate instance holds at 99 with co asserted, then counts down
    step(1'b0, 1'b1, 8'h99, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      s_en = 1'b1; s_load = 1'b0; s_up = 1'b1;
      #1;
      check("t4_sat_co", {31'd0, cos}, 32'd1);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      check("t4_sat_hold", {24'd0, qs}, 32'h99);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("t4_sat_down", {24'd0, qs}, 32'h98);

    // T6: cascade of two single-digit stages wraps exactly once in 100 up edges
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    wraps = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      if ({qc1, qc0} == 8'h00) wraps++;
    end
    check("t6_wraps", wraps, 32'd1);
    check("t6_final", {24'd0, qc1, qc0}, 32'h00);

    // Random traffic against the decimal models
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
           8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
